// File: rtl/csr_timer_unit.sv
// Countdown timer + interrupt source owning TID/TCFG/TVAL/TICLR, optional 64-bit stable counter.
// Latency: CSR reads combinational; writes and timer state update on the next clk edge.
// Backpressure: none; every CSR access is accepted in the cycle it is presented.
//
// Ports: clk/resetn (sync, active low); csr_re/csr_num/csr_rvalue/csr_hit read side;
//   csr_we/csr_wmask/csr_wvalue write side; timer_int -> ESTAT.IS[11];
//   cnt_value (stable counter, 0 unless STABLE_CNT_EN defined); cnt_id = TID.
// Build option: define STABLE_CNT_EN to instantiate the free-running 64-bit counter.
module csr_timer_unit #(
  parameter int          TIMER_N       = 32,
  parameter int          CSR_NUM_WIDTH = 14,
  parameter logic [31:0] TID_RESET     = 32'h0
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     csr_re,
  input  logic [CSR_NUM_WIDTH-1:0] csr_num,
  output logic [31:0]              csr_rvalue,
  output logic                     csr_hit,
  input  logic                     csr_we,
  input  logic [31:0]              csr_wmask,
  input  logic [31:0]              csr_wvalue,
  output logic                     timer_int,
  output logic [63:0]              cnt_value,
  output logic [31:0]              cnt_id
);

  localparam logic [CSR_NUM_WIDTH-1:0] CSR_TID   = CSR_NUM_WIDTH'(14'h40);
  localparam logic [CSR_NUM_WIDTH-1:0] CSR_TCFG  = CSR_NUM_WIDTH'(14'h41);
  localparam logic [CSR_NUM_WIDTH-1:0] CSR_TVAL  = CSR_NUM_WIDTH'(14'h42);
  localparam logic [CSR_NUM_WIDTH-1:0] CSR_TICLR = CSR_NUM_WIDTH'(14'h44);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_EXPIRED = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [31:0]          r_tid;
  logic [TIMER_N-1:0]   r_tcfg;
  logic [TIMER_N-1:0]   r_tval;
  logic [TIMER_N-1:0]   w_tval_nxt;
  logic                 r_timer_int;
  logic                 w_int_nxt;

  logic                 w_sel_tid;
  logic                 w_sel_tcfg;
  logic                 w_sel_tval;
  logic                 w_sel_ticlr;
  logic                 w_tid_wr;
  logic                 w_tcfg_wr;
  logic                 w_ticlr;
  logic                 w_expire;
  logic [31:0]          w_tid_new;
  logic [TIMER_N-1:0]   w_tcfg_new;
  logic [TIMER_N-1:0]   w_tcfg_reload;
  logic [TIMER_N-1:0]   w_new_reload;
  logic [31:0]          w_tcfg_rd;
  logic [31:0]          w_tval_rd;

  // ---------------- CSR decode ----------------
  assign w_sel_tid   = (csr_num == CSR_TID);
  assign w_sel_tcfg  = (csr_num == CSR_TCFG);
  assign w_sel_tval  = (csr_num == CSR_TVAL);
  assign w_sel_ticlr = (csr_num == CSR_TICLR);
  assign csr_hit     = w_sel_tid | w_sel_tcfg | w_sel_tval | w_sel_ticlr;

  assign w_tid_wr  = csr_we & w_sel_tid;
  assign w_tcfg_wr = csr_we & w_sel_tcfg;
  // Only bit 0 of a TICLR write carries meaning.
  assign w_ticlr   = csr_we & w_sel_ticlr & csr_wmask[0] & csr_wvalue[0];

  assign w_tid_new  = (csr_wmask & csr_wvalue) | (~csr_wmask & r_tid);
  assign w_tcfg_new = (csr_wmask[TIMER_N-1:0] & csr_wvalue[TIMER_N-1:0])
                    | (~csr_wmask[TIMER_N-1:0] & r_tcfg);

  // Reload value is InitVal shifted into the upper bits; the low two bits are En/Periodic.
  assign w_tcfg_reload = {r_tcfg[TIMER_N-1:2], 2'b00};
  assign w_new_reload  = {w_tcfg_new[TIMER_N-1:2], 2'b00};

  assign w_expire = (r_state == S_RUN) && (r_tval == '0);

  // Zero-extend the TIMER_N-wide registers onto the 32-bit read bus.
  always_comb begin
    w_tcfg_rd = '0;
    w_tval_rd = '0;
    w_tcfg_rd[TIMER_N-1:0] = r_tcfg;
    w_tval_rd[TIMER_N-1:0] = r_tval;
  end

  always_comb begin
    csr_rvalue = '0;
    if (csr_re) begin
      if (w_sel_tid)  csr_rvalue = r_tid;
      if (w_sel_tcfg) csr_rvalue = w_tcfg_rd;
      if (w_sel_tval) csr_rvalue = w_tval_rd;
    end
  end

  // ---------------- FSM: next state / TVAL / interrupt ----------------
  always_comb begin
    w_state_nxt = r_state;
    w_tval_nxt  = r_tval;
    w_int_nxt   = r_timer_int;

    // Clear first so a coincident expiry below wins.
    if (w_ticlr)  w_int_nxt = 1'b0;
    if (w_expire) w_int_nxt = 1'b1;

    unique case (r_state)
      S_RUN: begin
        if (r_tval == '0) begin
          if (r_tcfg[1]) begin
            w_tval_nxt = w_tcfg_reload;
          end else begin
            w_tval_nxt  = '1;
            w_state_nxt = S_EXPIRED;
          end
        end else begin
          w_tval_nxt = r_tval - 1'b1;
        end
      end
      default: begin
        w_tval_nxt = r_tval;
      end
    endcase

    // A TCFG write overrides the countdown for TVAL and state (but not the interrupt set).
    if (w_tcfg_wr) begin
      if (w_tcfg_new[0]) begin
        w_tval_nxt  = w_new_reload;
        w_state_nxt = S_RUN;
      end else begin
        w_tval_nxt  = r_tval;
        w_state_nxt = S_IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state     <= S_IDLE;
      r_tid       <= TID_RESET;
      r_tcfg      <= '0;
      r_tval      <= '1;
      r_timer_int <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_tval      <= w_tval_nxt;
      r_timer_int <= w_int_nxt;
      if (w_tid_wr)  r_tid  <= w_tid_new;
      if (w_tcfg_wr) r_tcfg <= w_tcfg_new;
    end
  end

  assign timer_int = r_timer_int;
  assign cnt_id    = r_tid;

  // ---------------- optional stable counter ----------------
`ifdef STABLE_CNT_EN
  logic [63:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!resetn) r_cnt <= '0;
    else         r_cnt <= r_cnt + 64'd1;
  end

  assign cnt_value = r_cnt;
`else
  assign cnt_value = '0;
`endif

endmodule

// File: tb/tb_csr_timer_unit.sv
module tb_csr_timer_unit;

  localparam logic [31:0] TID_RST = 32'hA5A5_0000;
  localparam logic [13:0] A_TID   = 14'h40;
  localparam logic [13:0] A_TCFG  = 14'h41;
  localparam logic [13:0] A_TVAL  = 14'h42;
  localparam logic [13:0] A_TICLR = 14'h44;

  logic        clk = 1'b0;
  logic        resetn;
  logic        csr_re;
  logic [13:0] csr_num;
  logic [31:0] csr_rvalue;
  logic        csr_hit;
  logic        csr_we;
  logic [31:0] csr_wmask;
  logic [31:0] csr_wvalue;
  logic        timer_int;
  logic [63:0] cnt_value;
  logic [31:0] cnt_id;

  int n_checks = 0;
  int n_errors = 0;

  csr_timer_unit #(
    .TIMER_N       (32),
    .CSR_NUM_WIDTH (14),
    .TID_RESET     (TID_RST)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .csr_re     (csr_re),
    .csr_num    (csr_num),
    .csr_rvalue (csr_rvalue),
    .csr_hit    (csr_hit),
    .csr_we     (csr_we),
    .csr_wmask  (csr_wmask),
    .csr_wvalue (csr_wvalue),
    .timer_int  (timer_int),
    .cnt_value  (cnt_value),
    .cnt_id     (cnt_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        re;
    logic        we;
    logic [13:0] num;
    logic [31:0] mask;
    logic [31:0] wval;
    logic        exp_hit;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[17];

  function automatic vec_t mk(input logic re, input logic we, input logic [13:0] num,
                              input logic [31:0] mask, input logic [31:0] wval,
                              input logic exp_hit, input logic [31:0] exp_rd);
    vec_t v;
    v.re = re; v.we = we; v.num = num; v.mask = mask; v.wval = wval;
    v.exp_hit = exp_hit; v.exp_rd = exp_rd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Combinational read; does not advance the clock.
  task automatic rd(input logic [13:0] num, output logic [31:0] val);
    csr_re  = 1'b1;
    csr_num = num;
    #1;
    val     = csr_rvalue;
    csr_re  = 1'b0;
  endtask

  // Called just after a negedge; the write is sampled at the following posedge.
  task automatic wr(input logic [13:0] num, input logic [31:0] mask, input logic [31:0] val);
    csr_we     = 1'b1;
    csr_num    = num;
    csr_wmask  = mask;
    csr_wvalue = val;
    @(negedge clk);
    csr_we     = 1'b0;
    csr_wmask  = '0;
    csr_wvalue = '0;
  endtask

  // Counts clock edges until timer_int rises; a cycle budget bounds the wait.
  task automatic wait_int(output int cycles);
    cycles = 0;
    while (!timer_int && cycles < 100) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic wait_tval(input logic [31:0] target, input string name);
    logic [31:0] v;
    int          n;
    n = 0;
    rd(A_TVAL, v);
    while (v != target && n < 100) begin
      @(negedge clk);
      n++;
      rd(A_TVAL, v);
    end
    chk(name, v, target);
  endtask

  initial begin
    logic [31:0] v;
    int          cyc;

    resetn = 1'b0; csr_re = 1'b0; csr_we = 1'b0;
    csr_num = '0; csr_wmask = '0; csr_wvalue = '0;

    vecs[0]  = mk(1, 0, A_TID,   32'h0,         32'h0,         1, TID_RST);
    vecs[1]  = mk(1, 0, A_TCFG,  32'h0,         32'h0,         1, 32'h0);
    vecs[2]  = mk(1, 0, A_TVAL,  32'h0,         32'h0,         1, 32'hFFFF_FFFF);
    vecs[3]  = mk(1, 0, A_TICLR, 32'h0,         32'h0,         1, 32'h0);
    vecs[4]  = mk(1, 0, 14'h43,  32'h0,         32'h0,         0, 32'h0);
    vecs[5]  = mk(0, 0, A_TVAL,  32'h0,         32'h0,         1, 32'h0);
    vecs[6]  = mk(0, 1, A_TID,   32'hFFFF_0000, 32'h1234_5678, 1, 32'h0);
    vecs[7]  = mk(1, 0, A_TID,   32'h0,         32'h0,         1, 32'h1234_0000);
    vecs[8]  = mk(0, 1, A_TVAL,  32'hFFFF_FFFF, 32'h0000_1234, 1, 32'h0);
    vecs[9]  = mk(1, 0, A_TVAL,  32'h0,         32'h0,         1, 32'hFFFF_FFFF);
    vecs[10] = mk(1, 1, A_TID,   32'h0000_FFFF, 32'hABCD_ABCD, 1, 32'h1234_0000);
    vecs[11] = mk(1, 0, A_TID,   32'h0,         32'h0,         1, 32'h1234_ABCD);
    vecs[12] = mk(1, 0, 14'h1040, 32'h0,        32'h0,         0, 32'h0);
    vecs[13] = mk(0, 1, A_TCFG,  32'hFFFF_FFFF, 32'hFFFF_FFF0, 1, 32'h0);
    vecs[14] = mk(1, 0, A_TCFG,  32'h0,         32'h0,         1, 32'hFFFF_FFF0);
    vecs[15] = mk(1, 0, A_TVAL,  32'h0,         32'h0,         1, 32'hFFFF_FFFF);
    vecs[16] = mk(0, 1, A_TCFG,  32'hFFFF_FFFF, 32'h0,         1, 32'h0);

    repeat (3) @(negedge clk);
    chk("reset_int", {63'h0, timer_int}, 64'h0);
    chk("reset_cnt", cnt_value, 64'h0);
    chk("reset_cnt_id", {32'h0, cnt_id}, {32'h0, TID_RST});
    resetn = 1'b1;

    // Table-driven CSR decode/read/write vectors.
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      csr_re = vecs[i].re; csr_we = vecs[i].we; csr_num = vecs[i].num;
      csr_wmask = vecs[i].mask; csr_wvalue = vecs[i].wval;
      #1;
      chk($sformatf("vec%0d_hit", i), {63'h0, csr_hit}, {63'h0, vecs[i].exp_hit});
      chk($sformatf("vec%0d_rd", i), {32'h0, csr_rvalue}, {32'h0, vecs[i].exp_rd});
    end
    @(negedge clk);
    csr_re = 0; csr_we = 0; csr_wmask = '0; csr_wvalue = '0;
    chk("tbl_cnt_id", {32'h0, cnt_id}, 64'h1234_ABCD);
    chk("tbl_int", {63'h0, timer_int}, 64'h0);

    // One-shot: InitVal=4 -> TVAL 16, interrupt 17 edges after load.
    wr(A_TCFG, 32'hFFFF_FFFF, 32'h0000_0011);
    rd(A_TVAL, v);
    chk("oneshot_load", {32'h0, v}, 64'd16);
    wait_int(cyc);
    chk("oneshot_latency", cyc, 17);
    rd(A_TVAL, v);
    chk("oneshot_tval_ff", {32'h0, v}, 64'hFFFF_FFFF);
    repeat (5) @(negedge clk);
    rd(A_TVAL, v);
    chk("oneshot_tval_hold", {32'h0, v}, 64'hFFFF_FFFF);
    wr(A_TICLR, 32'h1, 32'h1);
    chk("oneshot_clear", {63'h0, timer_int}, 64'h0);
    repeat (30) @(negedge clk);
    chk("oneshot_no_second", {63'h0, timer_int}, 64'h0);

    // Periodic: InitVal=2 -> TVAL 8, interrupt every 9 edges.
    wr(A_TCFG, 32'hFFFF_FFFF, 32'h0000_000B);
    wait_int(cyc);
    chk("periodic_first", cyc, 9);
    wr(A_TICLR, 32'h1, 32'h1);
    chk("periodic_clear", {63'h0, timer_int}, 64'h0);
    wait_int(cyc);
    chk("periodic_second", cyc, 8);
    wr(A_TICLR, 32'h1, 32'h1);
    chk("periodic_clear2", {63'h0, timer_int}, 64'h0);
    wait_tval(32'h0, "periodic_reach0");
    // Clear lands on the same edge as the expiry: set must win.
    wr(A_TICLR, 32'h1, 32'h1);
    chk("clear_vs_set", {63'h0, timer_int}, 64'h1);
    rd(A_TVAL, v);
    chk("periodic_reload", {32'h0, v}, 64'd8);

    // Disable mid-count at TVAL=5: TVAL freezes, interrupt stays.
    wait_tval(32'd5, "reach5");
    wr(A_TCFG, 32'h0000_0001, 32'h0);
    rd(A_TVAL, v);
    chk("disable_hold", {32'h0, v}, 64'd5);
    chk("disable_int_sticky", {63'h0, timer_int}, 64'h1);
    repeat (3) @(negedge clk);
    rd(A_TVAL, v);
    chk("disable_hold_later", {32'h0, v}, 64'd5);
    rd(A_TCFG, v);
    chk("disable_tcfg", {32'h0, v}, 64'h0000_000A);
    wr(A_TVAL, 32'hFFFF_FFFF, 32'h0000_1234);
    rd(A_TVAL, v);
    chk("tval_ro", {32'h0, v}, 64'd5);

    // Reset mid-count with a pending interrupt.
    wr(A_TCFG, 32'hFFFF_FFFF, 32'h0000_0011);
    wait_tval(32'd3, "reach3");
    chk("pre_reset_int", {63'h0, timer_int}, 64'h1);
    resetn = 1'b0;
    @(negedge clk);
    rd(A_TVAL, v);
    chk("rst_tval", {32'h0, v}, 64'hFFFF_FFFF);
    rd(A_TCFG, v);
    chk("rst_tcfg", {32'h0, v}, 64'h0);
    rd(A_TID, v);
    chk("rst_tid", {32'h0, v}, {32'h0, TID_RST});
    chk("rst_int", {63'h0, timer_int}, 64'h0);
    chk("rst_cnt", cnt_value, 64'h0);
    resetn = 1'b1;

    // Stable counter: N edges after reset release.
    repeat (20) @(negedge clk);
`ifdef STABLE_CNT_EN
    chk("stable_cnt", cnt_value, 64'd20);
`else
    chk("stable_cnt_off", cnt_value, 64'h0);
`endif
    repeat (5) @(negedge clk);
    chk("rst_no_residual_int", {63'h0, timer_int}, 64'h0);

    // InitVal=0: TVAL loads 0, interrupt on the very next edge.
    wr(A_TCFG, 32'hFFFF_FFFF, 32'h0000_0001);
    rd(A_TVAL, v);
    chk("init0_load", {32'h0, v}, 64'h0);
    wait_int(cyc);
    chk("init0_latency", cyc, 1);
    rd(A_TVAL, v);
    chk("init0_expired", {32'h0, v}, 64'hFFFF_FFFF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
